// File: rtl/seq_control_unit.sv
// Sequencer for a 4-bit-PC, 8-bit-instruction micro-core.
// Every instruction runs FETCH -> DECODE -> EXECUTE -> WRITEBACK (4 cycles).
// Optional build macro: SEQ_ILLEGAL_TRAP_EN
//   defined   : an undefined opcode sets the sticky 'illegal' flag and halts
//   undefined : an undefined opcode behaves as NOP and 'illegal' stays 0
module seq_control_unit #(
    parameter int RETIRE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          instruction,
    input  logic                zero_flag,
    output logic                pc_inc,
    output logic                branch,
    output logic [3:0]          branchaddress,
    output logic [2:0]          alu_op,
    output logic [1:0]          rd_sel,
    output logic [1:0]          rs_sel,
    output logic                reg_we,
    output logic                flag_we,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    logic [2:0]          state_reg, state_next;
    logic [7:0]          ir_reg;
    logic                zf_reg;
    logic [RETIRE_W-1:0] retired_reg;

    logic [3:0] opcode;
    logic [2:0] alu_code;
    logic       is_alu, is_jmp, is_jz, is_halt;
    logic       take_branch, stop_after_wb;
    logic       in_wb, in_active;

    assign opcode    = ir_reg[7:4];
    assign in_wb     = (state_reg == S_WRITEBACK);
    assign in_active = (state_reg == S_DECODE) || (state_reg == S_EXECUTE) || in_wb;

    // Opcode decode from the latched IR only
    always_comb begin
        alu_code = 3'b000;
        is_alu   = 1'b0;
        is_jmp   = 1'b0;
        is_jz    = 1'b0;
        is_halt  = 1'b0;
        case (opcode)
            4'b0001: begin alu_code = 3'b001; is_alu = 1'b1; end
            4'b0010: begin alu_code = 3'b010; is_alu = 1'b1; end
            4'b0011: begin alu_code = 3'b011; is_alu = 1'b1; end
            4'b0100: begin alu_code = 3'b100; is_alu = 1'b1; end
            4'b0101: begin alu_code = 3'b101; is_alu = 1'b1; end
            4'b1000: is_jmp  = 1'b1;
            4'b1001: is_jz   = 1'b1;
            4'b1111: is_halt = 1'b1;
            default: ;
        endcase
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic is_illegal;
    logic illegal_reg;

    assign is_illegal    = !(is_alu || is_jmp || is_jz || is_halt || (opcode == 4'b0000));
    assign stop_after_wb = is_halt || is_illegal;
    assign illegal       = illegal_reg;

    // Sticky trap flag, set when an undefined opcode retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_reg <= 1'b0;
        else if (in_wb && is_illegal)
            illegal_reg <= 1'b1;
    end
`else
    assign stop_after_wb = is_halt;
    assign illegal       = 1'b0;
`endif

    // Next-state logic; HALT is only left through reset
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (start) state_next = S_FETCH;
            S_FETCH:     state_next = S_DECODE;
            S_DECODE:    state_next = S_EXECUTE;
            S_EXECUTE:   state_next = S_WRITEBACK;
            S_WRITEBACK: state_next = stop_after_wb ? S_HALT : S_FETCH;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_IDLE;
        endcase
    end

    // State, IR latch in FETCH, zero flag sample in EXECUTE, retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            ir_reg      <= 8'h00;
            zf_reg      <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH)
                ir_reg <= instruction;
            if (state_reg == S_EXECUTE)
                zf_reg <= zero_flag;
            if (in_wb && (retired_reg != {RETIRE_W{1'b1}}))
                retired_reg <= retired_reg + 1'b1;
        end
    end

    // Moore outputs: selects held DECODE..WRITEBACK, strobes only in WRITEBACK
    assign take_branch   = is_jmp || (is_jz && zf_reg);
    assign alu_op        = in_active ? alu_code    : 3'b000;
    assign rd_sel        = in_active ? ir_reg[3:2] : 2'b00;
    assign rs_sel        = in_active ? ir_reg[1:0] : 2'b00;
    assign reg_we        = in_wb && is_alu;
    assign flag_we       = in_wb && is_alu;
    assign branch        = in_wb && take_branch;
    assign branchaddress = branch ? ir_reg[3:0] : 4'h0;
    assign pc_inc        = in_wb && !take_branch && !stop_after_wb;
    assign halted        = (state_reg == S_HALT);
    assign retired       = retired_reg;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit. Outputs are sampled 1 ns after the
// rising edge; inputs are changed at the same point.
module tb_seq_control_unit;

    logic       clk = 1'b0;
    logic       rst_n, start, zero_flag;
    logic [7:0] instruction;
    logic       pc_inc, branch, reg_we, flag_we, halted, illegal;
    logic [3:0] branchaddress;
    logic [2:0] alu_op;
    logic [1:0] rd_sel, rs_sel;
    logic [7:0] retired;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int wb_cyc = 0;

    logic [2:0] c_alu [1:4];
    logic [1:0] c_rd  [1:4];
    logic [1:0] c_rs  [1:4];
    logic [3:0] c_ba  [1:4];
    logic       c_we  [1:4];
    logic       c_fwe [1:4];
    logic       c_pc  [1:4];
    logic       c_br  [1:4];
    logic       c_hlt [1:4];

    seq_control_unit #(.RETIRE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction),
        .zero_flag(zero_flag), .pc_inc(pc_inc), .branch(branch),
        .branchaddress(branchaddress), .alu_op(alu_op), .rd_sel(rd_sel),
        .rs_sel(rs_sel), .reg_we(reg_we), .flag_we(flag_we), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input int c);
        c_alu[c] = alu_op;  c_rd[c] = rd_sel;  c_rs[c] = rs_sel;
        c_ba[c]  = branchaddress;
        c_we[c]  = reg_we;  c_fwe[c] = flag_we;
        c_pc[c]  = pc_inc;  c_br[c]  = branch;  c_hlt[c] = halted;
    endtask

    task automatic do_reset();
        start = 1'b0; instruction = 8'h00; zero_flag = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // From IDLE: start for one cycle; returns in the FETCH cycle
    task automatic kick(input logic [7:0] ins);
        instruction = ins;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called in FETCH; captures cycles 1..4 and returns in WRITEBACK.
    // instruction is scrambled after FETCH and zero_flag is only valid in EXECUTE.
    task automatic run_instr(input logic [7:0] ins, input logic zf);
        instruction = ins;
        zero_flag = ~zf;
        cap(1);
        step();
        instruction = ~ins;
        cap(2);
        step();
        zero_flag = zf;
        cap(3);
        step();
        zero_flag = ~zf;
        cap(4);
        wb_cyc = cyc;
        $display("instr %02h zf=%0b: alu=%0d rd=%0d rs=%0d we=%0b pc_inc=%0b branch=%0b addr=%0h",
                 ins, zf, c_alu[2], c_rd[2], c_rs[2], c_we[4], c_pc[4], c_br[4], c_ba[4]);
    endtask

    task automatic test_reset();
        logic seen;
        start = 1'b0; instruction = 8'h16; zero_flag = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({pc_inc, branch, reg_we, flag_we, halted, illegal} !== 6'b0 || alu_op !== 3'b0 ||
            rd_sel !== 2'b0 || rs_sel !== 2'b0 || branchaddress !== 4'h0 || retired !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs got pc=%0b br=%0b we=%0b alu=%0h ret=%0d exp all zero",
                     pc_inc, branch, reg_we, alu_op, retired);
        end
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | pc_inc | branch | reg_we | (alu_op != 3'b0);
        end
        checks++;
        if (seen !== 1'b0 || retired !== 8'h0) begin
            errors++;
            $display("FAIL idle_without_start got activity=%0b retired=%0d exp 0 0", seen, retired);
        end
    endtask

    task automatic test_inc();
        do_reset();
        kick(8'h16);
        run_instr(8'h16, 1'b0);
        checks++;
        if (c_alu[1] !== 3'b000 || c_alu[2] !== 3'b001 || c_alu[3] !== 3'b001 || c_alu[4] !== 3'b001) begin
            errors++;
            $display("FAIL inc_alu_op got %0d %0d %0d %0d exp 0 1 1 1", c_alu[1], c_alu[2], c_alu[3], c_alu[4]);
        end
        checks++;
        if (c_rd[2] !== 2'b01 || c_rs[2] !== 2'b10 || c_rd[4] !== 2'b01 || c_rd[1] !== 2'b00) begin
            errors++;
            $display("FAIL inc_selects got rd=%0d rs=%0d rd_wb=%0d rd_f=%0d exp 1 2 1 0",
                     c_rd[2], c_rs[2], c_rd[4], c_rd[1]);
        end
        checks++;
        if ({c_we[1], c_we[2], c_we[3], c_we[4]} !== 4'b0001 ||
            {c_fwe[1], c_fwe[2], c_fwe[3], c_fwe[4]} !== 4'b0001) begin
            errors++;
            $display("FAIL inc_write_strobes got we=%b%b%b%b exp 0001", c_we[1], c_we[2], c_we[3], c_we[4]);
        end
        checks++;
        if ({c_pc[1], c_pc[2], c_pc[3], c_pc[4]} !== 4'b0001 || c_br[4] !== 1'b0) begin
            errors++;
            $display("FAIL inc_pc_inc got pc=%b%b%b%b br=%b exp 0001 0", c_pc[1], c_pc[2], c_pc[3], c_pc[4], c_br[4]);
        end
        step();
        checks++;
        if (retired !== 8'd1 || reg_we !== 1'b0 || alu_op !== 3'b000) begin
            errors++;
            $display("FAIL inc_retire got retired=%0d we=%0b alu=%0d exp 1 0 0", retired, reg_we, alu_op);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] first_alu;
        int         first_wb;
        do_reset();
        kick(8'h26);
        run_instr(8'h26, 1'b0);
        first_alu = c_alu[2];
        first_wb  = wb_cyc;
        step();
        run_instr(8'h36, 1'b0);
        checks++;
        if (first_alu !== 3'b010 || c_alu[2] !== 3'b011) begin
            errors++;
            $display("FAIL addsub_alu_op got %0d %0d exp 2 3", first_alu, c_alu[2]);
        end
        checks++;
        if (wb_cyc - first_wb !== 4 || c_pc[4] !== 1'b1 || c_pc[1] !== 1'b0) begin
            errors++;
            $display("FAIL addsub_spacing got gap=%0d pc=%0b exp 4 1", wb_cyc - first_wb, c_pc[4]);
        end
        step();
        checks++;
        if (retired !== 8'd2) begin
            errors++;
            $display("FAIL addsub_retired got %0d exp 2", retired);
        end
    endtask

    task automatic test_alu_ops();
        logic [7:0] ins_tab [0:2];
        logic [2:0] alu_tab [0:2];
        logic       we_tab  [0:2];
        ins_tab[0] = 8'h4D; alu_tab[0] = 3'b100; we_tab[0] = 1'b1;
        ins_tab[1] = 8'h5E; alu_tab[1] = 3'b101; we_tab[1] = 1'b1;
        ins_tab[2] = 8'h07; alu_tab[2] = 3'b000; we_tab[2] = 1'b0;
        do_reset();
        kick(ins_tab[0]);
        for (int i = 0; i < 3; i++) begin
            run_instr(ins_tab[i], 1'b0);
            checks++;
            if (c_alu[3] !== alu_tab[i] || c_we[4] !== we_tab[i] || c_fwe[4] !== we_tab[i] ||
                c_pc[4] !== 1'b1 || c_rd[3] !== ins_tab[i][3:2] || c_rs[3] !== ins_tab[i][1:0]) begin
                errors++;
                $display("FAIL alu_op_%02h got alu=%0d we=%0b pc=%0b rd=%0d exp alu=%0d we=%0b pc=1 rd=%0d",
                         ins_tab[i], c_alu[3], c_we[4], c_pc[4], c_rd[3], alu_tab[i], we_tab[i], ins_tab[i][3:2]);
            end
            step();
        end
    endtask

    task automatic test_jmp();
        do_reset();
        kick(8'h8B);
        run_instr(8'h8B, 1'b0);
        checks++;
        if (c_br[4] !== 1'b1 || c_ba[4] !== 4'hB || c_pc[4] !== 1'b0) begin
            errors++;
            $display("FAIL jmp_branch got br=%0b addr=%0h pc=%0b exp 1 b 0", c_br[4], c_ba[4], c_pc[4]);
        end
        checks++;
        if ((c_we[1] | c_we[2] | c_we[3] | c_we[4]) !== 1'b0 || c_ba[3] !== 4'h0 || c_br[3] !== 1'b0 ||
            c_alu[2] !== 3'b000) begin
            errors++;
            $display("FAIL jmp_quiet got we_any=%0b addr_exec=%0h br_exec=%0b alu=%0d exp 0 0 0 0",
                     c_we[1] | c_we[2] | c_we[3] | c_we[4], c_ba[3], c_br[3], c_alu[2]);
        end
    endtask

    task automatic test_jz();
        do_reset();
        kick(8'h93);
        run_instr(8'h93, 1'b0);
        checks++;
        if (c_pc[4] !== 1'b1 || c_br[4] !== 1'b0 || c_ba[4] !== 4'h0) begin
            errors++;
            $display("FAIL jz_not_taken got pc=%0b br=%0b addr=%0h exp 1 0 0", c_pc[4], c_br[4], c_ba[4]);
        end
        step();
        run_instr(8'h93, 1'b1);
        checks++;
        if (c_pc[4] !== 1'b0 || c_br[4] !== 1'b1 || c_ba[4] !== 4'h3) begin
            errors++;
            $display("FAIL jz_taken got pc=%0b br=%0b addr=%0h exp 0 1 3", c_pc[4], c_br[4], c_ba[4]);
        end
        step();
        checks++;
        if (retired !== 8'd2 || branch !== 1'b0) begin
            errors++;
            $display("FAIL jz_retired got %0d br=%0b exp 2 0", retired, branch);
        end
    endtask

    task automatic test_halt();
        logic seen;
        do_reset();
        kick(8'hF0);
        run_instr(8'hF0, 1'b0);
        checks++;
        if (c_pc[4] !== 1'b0 || c_br[4] !== 1'b0 || c_hlt[4] !== 1'b0) begin
            errors++;
            $display("FAIL halt_wb got pc=%0b br=%0b halted=%0b exp 0 0 0", c_pc[4], c_br[4], c_hlt[4]);
        end
        step();
        checks++;
        if (halted !== 1'b1 || retired !== 8'd1) begin
            errors++;
            $display("FAIL halt_entered got halted=%0b retired=%0d exp 1 1", halted, retired);
        end
        start = 1'b1;
        instruction = 8'h16;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | pc_inc | branch | reg_we | ~halted;
        end
        start = 1'b0;
        checks++;
        if (seen !== 1'b0 || retired !== 8'd1) begin
            errors++;
            $display("FAIL halt_ignores_start got activity=%0b retired=%0d exp 0 1", seen, retired);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || retired !== 8'd0) begin
            errors++;
            $display("FAIL halt_reset got halted=%0b retired=%0d exp 0 0", halted, retired);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_illegal();
        do_reset();
        kick(8'hA0);
        run_instr(8'hA0, 1'b0);
        step();
`ifdef SEQ_ILLEGAL_TRAP_EN
        checks++;
        if (c_pc[4] !== 1'b0 || illegal !== 1'b1 || halted !== 1'b1) begin
            errors++;
            $display("FAIL illegal_trap got pc=%0b illegal=%0b halted=%0b exp 0 1 1", c_pc[4], illegal, halted);
        end
`else
        checks++;
        if (c_pc[4] !== 1'b1 || illegal !== 1'b0 || halted !== 1'b0 || c_we[4] !== 1'b0) begin
            errors++;
            $display("FAIL illegal_as_nop got pc=%0b illegal=%0b halted=%0b we=%0b exp 1 0 0 0",
                     c_pc[4], illegal, halted, c_we[4]);
        end
`endif
        checks++;
        if (retired !== 8'd1) begin
            errors++;
            $display("FAIL illegal_retired got %0d exp 1", retired);
        end
    endtask

    task automatic test_abort();
        logic seen;
        do_reset();
        kick(8'h16);
        instruction = 8'h16;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (alu_op !== 3'b000 || rd_sel !== 2'b00 || reg_we !== 1'b0 || pc_inc !== 1'b0) begin
            errors++;
            $display("FAIL abort_immediate got alu=%0d rd=%0d we=%0b pc=%0b exp 0 0 0 0", alu_op, rd_sel, reg_we, pc_inc);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) rst_n = 1'b1;
            seen = seen | pc_inc | branch | reg_we | flag_we;
        end
        checks++;
        if (seen !== 1'b0 || retired !== 8'd0) begin
            errors++;
            $display("FAIL abort_no_strobes got activity=%0b retired=%0d exp 0 0", seen, retired);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        kick(8'h00);
        instruction = 8'h00;
        repeat (254 * 4) step();
        checks++;
        if (retired !== 8'd254) begin
            errors++;
            $display("FAIL retire_count got %0d exp 254", retired);
        end
        repeat (4 * 4) step();
        checks++;
        if (retired !== 8'hFF) begin
            errors++;
            $display("FAIL retire_saturate got %0d exp 255", retired);
        end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_back_to_back();
        test_alu_ops();
        test_jmp();
        test_jz();
        test_halt();
        test_illegal();
        test_abort();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 SHALL provide parameter RETIRE_W, default 8, width of the retired-instruction counter.
REQ-002 SHALL provide port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port start  input  1  level/pulse; begins execution when sampled high in IDLE.
REQ-005 SHALL provide port instruction  input  8  current ROM word; [7:4] opcode, [3:2] rd, [1:0] rs.
REQ-006 SHALL provide port zero_flag  input  1  ALU zero flag from the register/ALU datapath.
REQ-007 SHALL provide port pc_inc  output  1  one-cycle pulse; instruction memory advances PC by 1 (4-bit wrap 15->0).
REQ-008 SHALL provide port branch  output  1  one-cycle pulse; instruction memory loads branchaddress.
REQ-009 SHALL provide port branchaddress  output  4  jump target, valid while branch=1, else 0.
REQ-010 SHALL provide port alu_op  output  3  ALU operation select.
REQ-011 SHALL provide ports rd_sel, rs_sel  output  2 each  register selects.
REQ-012 SHALL provide ports reg_we, flag_we  output  1 each  register/flag write strobes.
REQ-013 SHALL provide port halted  output  1  high in HALT state.
REQ-014 SHALL provide port illegal  output  1  sticky flag, undefined opcode executed.
REQ-015 SHALL provide port retired  output  RETIRE_W  count of completed instructions.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-017 Transitions SHALL be: IDLE->FETCH on start=1; FETCH->DECODE->EXECUTE->WRITEBACK unconditionally; WRITEBACK->FETCH, or WRITEBACK->HALT for opcode 1111; HALT exits only via reset.
REQ-018 FETCH SHALL latch instruction into an internal 8-bit IR; later states SHALL use IR only.
REQ-019 Opcodes SHALL decode as: 0000 NOP; 0001 INC rd; 0010 ADD; 0011 SUB; 0100 AND; 0101 MOV rd<-rs; 1000 JMP; 1001 JZ; 1111 HALT; others illegal.
REQ-020 alu_op SHALL be INC=001, ADD=010, SUB=011, AND=100, MOV=101, otherwise 000, with rd_sel/rs_sel=IR fields, held from DECODE through WRITEBACK; 0 in other states.
REQ-021 reg_we and flag_we SHALL pulse high for exactly the WRITEBACK cycle of INC/ADD/SUB/AND/MOV; never otherwise.
REQ-022 JMP/JZ target SHALL be {IR[3:2],IR[1:0]}; zero_flag SHALL be sampled in EXECUTE for JZ.
REQ-023 In WRITEBACK exactly one of pc_inc or branch SHALL pulse: branch for JMP or JZ-taken, pc_inc otherwise, neither for HALT.
REQ-024 Every instruction SHALL take exactly 4 cycles FETCH-to-WRITEBACK inclusive.
REQ-025 retired SHALL increment in each WRITEBACK including HALT, saturating at all-ones (no wrap).
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 A branch target equal to the current PC SHALL be legal (spin loop) with no special handling.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, IR=0, all strobes/selects/branchaddress=0, halted=0, illegal=0, retired=0.
REQ-029 Reset asserted mid-instruction SHALL abort it with no reg_we, flag_we, pc_inc or branch issued.
REQ-030 After rst_n release the block SHALL remain in IDLE until start=1.

Configuration
REQ-031 Macro SEQ_ILLEGAL_TRAP_EN defined: illegal opcode SHALL set illegal=1 and go WRITEBACK->HALT with no pc_inc.
REQ-032 Macro SEQ_ILLEGAL_TRAP_EN undefined: illegal opcode SHALL execute as NOP (pc_inc in WRITEBACK) and illegal SHALL be tied 0.

Verification
REQ-033 Reset, start=1 one cycle, instruction=8'h16 (INC R1) -> alu_op=001, rd_sel=01 from DECODE; reg_we=flag_we=pc_inc=1 only in cycle 4 after start; retired=1.
REQ-034 instruction=8'h26 (ADD R1,R2) then 8'h36 (SUB R1,R2) -> alu_op 010 then 011; pc_inc pulses 4 cycles apart; retired=2.
REQ-035 instruction=8'h8B (JMP 11) -> branch=1, branchaddress=4'hB, pc_inc=0 in WRITEBACK; reg_we never high.
REQ-036 8'h93 (JZ 3) with zero_flag=0 -> pc_inc=1, branch=0; repeated with zero_flag=1 -> branch=1, branchaddress=3.
REQ-037 8'hF0 (HALT) -> halted=1 from cycle 5 onward, no pc_inc/branch; start=1 ignored; rst_n=0 -> IDLE, retired=0.
REQ-038 8'hA0 with SEQ_ILLEGAL_TRAP_EN -> illegal=1, halted=1; without it -> illegal=0, pc_inc=1; plus rst_n=0 during EXECUTE -> no strobes.
